// File: rtl/clock_core.sv
// clock_core: the alarm clock's timekeeping core.
// It holds the running BCD time HH:MM:SS and advances it by one second on
// each tick_1hz. A load strobe copies the set-clock digits into the running
// time. The core also compares the running time with the alarm digits and
// drives a timed ringing output.
//
// Ports
//   clk                          system clock, rising edge
//   reset                        asynchronous, active-high
//   tick_1hz                     one-clk enable, once per second
//   load                         copy set_* into HH:MM and clear seconds
//   set_h1/h0/m1/m0    [3:0]     BCD time to load
//   alarm_en                     alarm armed while high
//   alarm_h1/h0/m1/m0  [3:0]     BCD alarm time
//   stop                         silences a ringing alarm
//   h1/h0/m1/m0/s1/s0  [3:0]     running time, registered
//   alarm_ring                   registered, high while ringing
module clock_core #(
   parameter int unsigned RING_SECONDS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       load,
   input  logic [3:0] set_h1,
   input  logic [3:0] set_h0,
   input  logic [3:0] set_m1,
   input  logic [3:0] set_m0,
   input  logic       alarm_en,
   input  logic [3:0] alarm_h1,
   input  logic [3:0] alarm_h0,
   input  logic [3:0] alarm_m1,
   input  logic [3:0] alarm_m0,
   input  logic       stop,
   output logic [3:0] h1,
   output logic [3:0] h0,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       alarm_ring
);

   localparam logic [7:0] RING_LIMIT = RING_SECONDS[7:0];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   logic [3:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
   logic [3:0] h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
   state_t     state_q;
   logic [7:0] ring_cnt_q;
   logic       alarm_ring_q;

   logic       set_valid;
   logic       load_ok;
   logic       hhmm_eq;
   logic       match;
   logic [7:0] ring_cnt_inc;

   // An out-of-range set value is treated as if load were low, so a
   // coincident tick still advances the time.
   assign set_valid = (set_m0 <= 4'd9) && (set_m1 <= 4'd5) && (set_h0 <= 4'd9) &&
                      ((set_h1 < 4'd2) || ((set_h1 == 4'd2) && (set_h0 <= 4'd3)));
   assign load_ok   = load & set_valid;

   always_comb begin
      h1_d = h1_q;
      h0_d = h0_q;
      m1_d = m1_q;
      m0_d = m0_q;
      s1_d = s1_q;
      s0_d = s0_q;
      if (load_ok) begin
         h1_d = set_h1;
         h0_d = set_h0;
         m1_d = set_m1;
         m0_d = set_m0;
         s1_d = 4'd0;
         s0_d = 4'd0;
      end else if (tick_1hz) begin
         // Ripple carry through the BCD digits, each with its own wrap point.
         if (s0_q != 4'd9) begin
            s0_d = s0_q + 4'd1;
         end else begin
            s0_d = 4'd0;
            if (s1_q != 4'd5) begin
               s1_d = s1_q + 4'd1;
            end else begin
               s1_d = 4'd0;
               if (m0_q != 4'd9) begin
                  m0_d = m0_q + 4'd1;
               end else begin
                  m0_d = 4'd0;
                  if (m1_q != 4'd5) begin
                     m1_d = m1_q + 4'd1;
                  end else begin
                     m1_d = 4'd0;
                     if ((h1_q == 4'd2) && (h0_q == 4'd3)) begin
                        h1_d = 4'd0;
                        h0_d = 4'd0;
                     end else if (h0_q == 4'd9) begin
                        h0_d = 4'd0;
                        h1_d = h1_q + 4'd1;
                     end else begin
                        h0_d = h0_q + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h1_q <= 4'd0;
         h0_q <= 4'd0;
         m1_q <= 4'd0;
         m0_q <= 4'd0;
         s1_q <= 4'd0;
         s0_q <= 4'd0;
      end else begin
         h1_q <= h1_d;
         h0_q <= h0_d;
         m1_q <= m1_d;
         m0_q <= m0_d;
         s1_q <= s1_d;
         s0_q <= s0_d;
      end
   end

   // Compare on the registered time, so the ring starts one clk after the
   // time reaches HH:MM:00.
   assign hhmm_eq      = ({h1_q, h0_q, m1_q, m0_q} == {alarm_h1, alarm_h0, alarm_m1, alarm_m0});
   assign match        = alarm_en & hhmm_eq & (s1_q == 4'd0) & (s0_q == 4'd0);
   assign ring_cnt_inc = ring_cnt_q + 8'd1;

   // DONE holds off re-triggering until the alarm minute has passed or the
   // alarm is disarmed. A load while ringing does not affect this FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ring_cnt_q   <= 8'd0;
         alarm_ring_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (match) begin
                  state_q      <= ST_RINGING;
                  ring_cnt_q   <= 8'd0;
                  alarm_ring_q <= 1'b1;
               end
            end
            ST_RINGING: begin
               if (stop || !alarm_en) begin
                  state_q      <= ST_DONE;
                  alarm_ring_q <= 1'b0;
               end else if (tick_1hz) begin
                  ring_cnt_q <= ring_cnt_inc;
                  if (ring_cnt_inc == RING_LIMIT) begin
                     state_q      <= ST_DONE;
                     alarm_ring_q <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (!hhmm_eq || !alarm_en) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               alarm_ring_q <= 1'b0;
            end
         endcase
      end
   end

   assign h1         = h1_q;
   assign h0         = h0_q;
   assign m1         = m1_q;
   assign m0         = m0_q;
   assign s1         = s1_q;
   assign s0         = s0_q;
   assign alarm_ring = alarm_ring_q;

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: self-checking bench for clock_core. It applies a vector
// table, then hand-written alarm sequences, then a randomized run checked
// against a seconds-of-day reference model.
module tb_clock_core;

   localparam int RING = 60;
   localparam int RAND_CYCLES = 2500;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_1hz, load, alarm_en, stop;
   logic [3:0] set_h1, set_h0, set_m1, set_m0;
   logic [3:0] alarm_h1, alarm_h0, alarm_m1, alarm_m0;
   logic [3:0] h1, h0, m1, m0, s1, s0;
   logic       alarm_ring;

   always #5 clk = ~clk;

   clock_core #(.RING_SECONDS(RING)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load),
      .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
      .alarm_en(alarm_en),
      .alarm_h1(alarm_h1), .alarm_h0(alarm_h0), .alarm_m1(alarm_m1), .alarm_m0(alarm_m0),
      .stop(stop),
      .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
      .alarm_ring(alarm_ring)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Scoreboard entries are {hhmmss BCD, alarm_ring}.
   logic [24:0] exp_q[$];

   // Reference model: time as seconds of day, alarm as a few flags.
   int m_t;
   bit m_ring;
   bit m_spent;
   int m_heard;

   typedef struct {
      logic [15:0] set;
      logic        ld;
      logic        tk;
      int          n;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[14];

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [23:0] exp_t, input logic exp_r);
      tests_run++;
      if ({h1, h0, m1, m0, s1, s0} !== exp_t || alarm_ring !== exp_r) begin
         tests_failed++;
         $display("FAIL %s: got time=%h ring=%b, expected time=%h ring=%b",
                  name, {h1, h0, m1, m0, s1, s0}, alarm_ring, exp_t, exp_r);
      end
   endtask

   task automatic cyc(input logic tk);
      load = 1'b0;
      tick_1hz = tk;
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
   endtask

   task automatic do_load(input logic [15:0] set, input logic tk);
      {set_h1, set_h0, set_m1, set_m0} = set;
      load = 1'b1;
      tick_1hz = tk;
      @(posedge clk);
      #1;
      load = 1'b0;
      tick_1hz = 1'b0;
   endtask

   task automatic set_alarm(input logic [15:0] a, input logic en);
      {alarm_h1, alarm_h0, alarm_m1, alarm_m0} = a;
      alarm_en = en;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [23:0] bcd_time(input int t);
      int hh, mm, ss;
      hh = t / 3600;
      mm = (t / 60) % 60;
      ss = t % 60;
      return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Advance the model by one clk edge using the inputs currently driven.
   task automatic model_edge();
      int  alarm_min, cur_min, hh, mm;
      bit  is_match, set_ok;
      alarm_min = (alarm_h1 * 10 + alarm_h0) * 60 + alarm_m1 * 10 + alarm_m0;
      cur_min   = m_t / 60;
      is_match  = alarm_en && (cur_min == alarm_min) && (m_t % 60 == 0);
      if (m_ring) begin
         if (stop || !alarm_en) begin
            m_ring = 0;
            m_spent = 1;
         end else if (tick_1hz) begin
            m_heard++;
            if (m_heard == RING) begin
               m_ring = 0;
               m_spent = 1;
            end
         end
      end else if (m_spent) begin
         if (cur_min != alarm_min || !alarm_en) m_spent = 0;
      end else if (is_match) begin
         m_ring = 1;
         m_heard = 0;
      end
      hh = set_h1 * 10 + set_h0;
      mm = set_m1 * 10 + set_m0;
      set_ok = (set_h0 <= 9) && (set_m0 <= 9) && (set_m1 <= 5) && (hh <= 23);
      if (load && set_ok) m_t = hh * 3600 + mm * 60;
      else if (tick_1hz) m_t = (m_t + 1) % 86400;
      exp_q.push_back({bcd_time(m_t), m_ring});
   endtask

   function automatic logic [15:0] rand_set();
      int hh, mm;
      case ($urandom_range(0, 4))
         0: return 16'h0629;
         1: return 16'h0630;
         2: return 16'h0631;
         3: begin
            hh = $urandom_range(0, 23);
            mm = $urandom_range(0, 59);
            return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
         end
         default: return 16'($urandom_range(0, 65535));
      endcase
   endfunction

   // ---------------- test ----------------
   initial begin
      logic [24:0] exp_v;

      vecs[0]  = '{16'h2359, 1'b1, 1'b0, 0,  24'h235900};
      vecs[1]  = '{16'h2359, 1'b1, 1'b0, 59, 24'h235959};
      vecs[2]  = '{16'h0000, 1'b0, 1'b1, 0,  24'h000000};
      vecs[3]  = '{16'h0815, 1'b1, 1'b1, 0,  24'h081500};
      vecs[4]  = '{16'h2400, 1'b1, 1'b1, 0,  24'h081501};
      vecs[5]  = '{16'h0760, 1'b1, 1'b1, 0,  24'h081502};
      vecs[6]  = '{16'h0959, 1'b1, 1'b0, 60, 24'h100000};
      vecs[7]  = '{16'h1959, 1'b1, 1'b0, 60, 24'h200000};
      vecs[8]  = '{16'h0859, 1'b1, 1'b0, 61, 24'h090001};
      vecs[9]  = '{16'h2a00, 1'b1, 1'b0, 0,  24'h090001};
      vecs[10] = '{16'h3000, 1'b1, 1'b1, 0,  24'h090002};
      vecs[11] = '{16'h1270, 1'b1, 1'b0, 0,  24'h090002};
      vecs[12] = '{16'h0000, 1'b1, 1'b0, 0,  24'h000000};
      vecs[13] = '{16'h1234, 1'b1, 1'b0, 3,  24'h123403};

      // clock/reset block, with the alarm armed at 00:00
      reset = 1'b1;
      tick_1hz = 1'b0;
      load = 1'b0;
      stop = 1'b0;
      {set_h1, set_h0, set_m1, set_m0} = 16'h0000;
      set_alarm(16'h0000, 1'b1);
      #12;
      check("reset_state", 24'h000000, 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("ring_after_release", 24'h000000, 1'b1);
      stop = 1'b1;
      cyc(1'b0);
      stop = 1'b0;
      check("stop_after_release", 24'h000000, 1'b0);
      alarm_en = 1'b0;
      cyc(1'b0);

      // vector table, alarm disarmed
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].ld) do_load(vecs[i].set, vecs[i].tk);
         else cyc(vecs[i].tk);
         ticks(vecs[i].n);
         check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      end

      // asynchronous reset in the middle of a ring
      set_alarm(16'h1234, 1'b1);
      do_load(16'h1234, 1'b0);
      cyc(1'b0);
      check("ring_1234", 24'h123400, 1'b1);
      ticks(56);
      check("ring_123456", 24'h123456, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_reset", 24'h000000, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      alarm_en = 1'b0;
      ticks(3);
      check("count_after_reset", 24'h000003, 1'b0);

      // alarm timeout at 06:30, including a reload during the ring
      set_alarm(16'h0630, 1'b1);
      do_load(16'h0629, 1'b0);
      ticks(59);
      check("pre_alarm_062959", 24'h062959, 1'b0);
      cyc(1'b1);
      check("reach_063000", 24'h063000, 1'b0);
      cyc(1'b0);
      check("ring_rise", 24'h063000, 1'b1);
      ticks(30);
      check("ring_30_ticks", 24'h063030, 1'b1);
      do_load(16'h0630, 1'b0);
      check("load_in_ring", 24'h063000, 1'b1);
      ticks(29);
      check("ring_59_ticks", 24'h063029, 1'b1);
      cyc(1'b1);
      check("timeout", 24'h063030, 1'b0);
      ticks(10);
      check("no_rering_0630", 24'h063040, 1'b0);

      // stop, reload within the same minute, then rearm after 06:31
      ticks(20);
      cyc(1'b0);
      do_load(16'h0630, 1'b0);
      cyc(1'b0);
      check("ring_again", 24'h063000, 1'b1);
      ticks(5);
      stop = 1'b1;
      cyc(1'b0);
      stop = 1'b0;
      check("stop", 24'h063005, 1'b0);
      do_load(16'h0630, 1'b0);
      cyc(1'b0);
      check("same_minute_reload", 24'h063000, 1'b0);
      do_load(16'h0631, 1'b0);
      cyc(1'b0);
      do_load(16'h0630, 1'b0);
      check("rearm_load", 24'h063000, 1'b0);
      cyc(1'b0);
      check("rearm_ring", 24'h063000, 1'b1);

      // disable while ringing, re-enable with seconds not 00
      ticks(2);
      alarm_en = 1'b0;
      cyc(1'b0);
      check("disable", 24'h063002, 1'b0);
      cyc(1'b0);
      ticks(3);
      alarm_en = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      check("reenable_no_ring", 24'h063005, 1'b0);

      // randomized run against the reference model
      reset = 1'b1;
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_t = 0;
      m_ring = 0;
      m_spent = 0;
      m_heard = 0;
      set_alarm(16'h0630, 1'b1);
      for (int c = 0; c < RAND_CYCLES; c++) begin
         load = ($urandom_range(0, 15) == 0);
         {set_h1, set_h0, set_m1, set_m0} = rand_set();
         tick_1hz = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 127) == 0) alarm_en = ~alarm_en;
         model_edge();
         @(posedge clk);
         #1;
         exp_v = exp_q.pop_front();
         tests_run++;
         if ({h1, h0, m1, m0, s1, s0, alarm_ring} !== exp_v) begin
            tests_failed++;
            $display("FAIL rand_cycle%0d: got time=%h ring=%b, expected time=%h ring=%b",
                     c, {h1, h0, m1, m0, s1, s0}, alarm_ring, exp_v[24:1], exp_v[0]);
         end
      end
      load = 1'b0;
      tick_1hz = 1'b0;
      stop = 1'b0;

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/clock_core.md
# clock_core

Timekeeping core for the alarm clock: holds the running BCD time HH:MM:SS, advances it on a 1 Hz enable pulse, and accepts the hour/minute digits produced by the set-clock block on a load strobe. It compares the running time against the alarm digits and drives a timed ringing output with stop and disable. It consumes the set-clock block's digits and feeds the display path.

## Interface
Parameters:
- RING_SECONDS, 60: number of tick_1hz pulses alarm_ring stays high; legal 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge except reset.
- reset  in  1  asynchronous, active-high.
- tick_1hz  in  1  one-clk-wide enable, one per second.
- load  in  1  synchronous strobe; copy set digits into the running time.
- set_h1, set_h0, set_m1, set_m0  in  4 each  BCD hour tens/units, minute tens/units to load.
- alarm_en  in  1  level; alarm armed when high.
- alarm_h1, alarm_h0, alarm_m1, alarm_m0  in  4 each  BCD alarm time.
- stop  in  1  synchronous level; silences a ringing alarm.
- h1, h0, m1, m0, s1, s0  out  4 each  running time, BCD, registered.
- alarm_ring  out  1  registered; high while the alarm sounds.

## Operation
- Reset: all time digits 0 (00:00:00), alarm FSM IDLE, ring counter 0, alarm_ring 0.
- Tick: on a clk edge with tick_1hz=1 and load=0, time increments by one second in BCD.
  - s0 9→0 carries into s1; s1 5→0 carries into m0; m0 9→0 into m1; m1 5→0 into hours.
  - Hours: h0 increments; 09→10, 19→20, 23→00 (h1=2, h0=3 wraps both to 0).
  - 23:59:59 → 00:00:00.
- Load: on a clk edge with load=1, h1..m0 take set_*; s1 and s0 clear to 0.
  - Load has priority over tick in the same cycle; that tick is dropped.
  - Invalid set value (set_m0>9, set_m1>5, set_h0>9, set_h1>2, or set_h1=2 with set_h0>3): load ignored, time unchanged, tick in that cycle still applied.
- Alarm match: match = alarm_en & (h1,h0,m1,m0 == alarm_*) & (s1=0, s0=0). It is evaluated on the registered time.
- Alarm FSM:
  - IDLE → RINGING when match=1. Ring counter clears to 0.
  - RINGING: the ring counter increments on each tick_1hz.
    - → DONE when stop=1, alarm_en=0, or the counter reaches RING_SECONDS (the counter value is checked after the increment).
    - Priority: stop/alarm_en over timeout; all give the same result.
  - DONE → IDLE when hh:mm ≠ alarm hh:mm, or when alarm_en=0. This prevents re-trigger within the matching minute.
- alarm_ring = 1 exactly when state = RINGING.
- Load during RINGING does not change the FSM; only stop, disable, or timeout end ringing.
- Loading exactly the alarm time (seconds cleared to 00) with alarm_en=1 triggers the alarm.
- Reset with alarm at 00:00 and alarm_en=1 rings after the first clk edge following reset release.

## Timing
- Tick or load sampled at edge N: new digits visible after edge N.
- match is computed combinationally from the registered digits. The FSM registers it at edge N+1, so alarm_ring rises one clk after the time reaches HH:MM:00.
- stop or alarm_en=0 sampled at edge K: alarm_ring low after edge K.
- Timeout: alarm_ring falls at the edge sampling the RING_SECONDS-th tick after entry. A tick coincident with the entry edge does not count.
- Reset is asynchronous: outputs go to reset values immediately, mid-count or mid-ring. Release is synchronous to the next clk edge.
- No combinational path from any input to any output.

## Test plan
- Reset mid-count at 12:34:56 with alarm ringing -> immediately 00:00:00, alarm_ring=0. After release, 3 ticks -> 00:00:03.
- Load set=23:59, then 60 ticks -> 00:00:00 after the 1st tick past 23:59:59; digits correct at 23:59:59 (h1=2 h0=3 m1=5 m0=9 s1=5 s0=9).
- Load with tick in the same cycle, set=08:15 -> 08:15:00, tick dropped. Load set=24:00 or 07:60 -> time unchanged, coincident tick applied.
- alarm=06:30, alarm_en=1, load 06:29, tick through 06:29:59 -> alarm_ring=1 one clk after 06:30:00. It stays high for RING_SECONDS=60 ticks, then 0, with no re-ring during 06:30.
- Ringing, assert stop for 1 clk -> alarm_ring=0 next edge. Then load 06:30 again within the same minute -> no ring. Advance to 06:31, then load 06:30 -> rings.
- Ringing, drop alarm_en -> alarm_ring=0 next edge, FSM returns to IDLE. Re-enable at 06:30:xx with seconds ≠ 00 -> no ring.
